instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit instruction words held.
REQ-002 Parameter NOP_WORD, default 32'h00000013: word driven whenever no valid instruction exists (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_valid  input  1  host presents a program word.
REQ-006 load_data  input  32  program word.
REQ-007 load_last  input  1  marks the final word of the program.
REQ-008 load_ready  output  1  loader accepts a word this cycle.
REQ-009 reload  input  1  discard the current program and return to IDLE.
REQ-010 PC  input  32  byte fetch address from the processor's PC_out.
REQ-011 Instruction  output  32  fetched word, driven to the processor's Instruction input.
REQ-012 cpu_run  output  1  processor may advance; high only in RUN.
REQ-013 load_count  output  7  number of words loaded, 0..DEPTH.
REQ-014 fault  output  1  sticky fetch fault.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN, and FAULT (FAULT exists only with the macro).
REQ-016 IDLE: load_ready=1; a load_valid handshake writes word 0 and moves to LOAD, or to RUN if load_last=1.
REQ-017 LOAD: load_ready=1; each valid&ready cycle writes mem[load_count] and increments load_count.
REQ-018 LOAD exits to RUN on a handshake with load_last=1, or when the write fills entry DEPTH-1, whichever occurs first.
REQ-019 When the buffer fills with load_last=0, the block SHALL still enter RUN; the host sees load_ready=0 from the next cycle on.
REQ-020 RUN: load_ready=0; cpu_run=1; Instruction = mem[PC[31:2]] combinationally, with zero latency, for a single-cycle core.
REQ-021 In every state, Instruction SHALL equal NOP_WORD when PC[31:2] >= load_count, and whenever the state is not RUN.
REQ-022 A written word SHALL be readable from the cycle after its handshake.
REQ-023 reload=1 in any state SHALL move to IDLE next cycle and set load_count=0; memory contents may be kept but are masked by REQ-021.
REQ-024 If reload and load_valid are both high, reload SHALL win and the word SHALL not be counted.

Reset
REQ-025 While reset=1: state=IDLE, load_count=0, fault=0, cpu_run=0, load_ready=1, Instruction=NOP_WORD.
REQ-026 Reset asserted mid-load SHALL discard the partial program; the memory array itself is not cleared.

Configuration
REQ-027 With IMEM_FAULT_EN defined, in RUN a PC with PC[1:0]!=0 or PC[31:2]>=load_count SHALL move the block to FAULT next cycle.
REQ-028 In FAULT: fault=1, cpu_run=0, Instruction=NOP_WORD, load_ready=0; the block leaves FAULT only on reload or reset.
REQ-029 Without IMEM_FAULT_EN: there is no FAULT state; fault is tied 0; out-of-range or misaligned fetches return NOP_WORD (misaligned fetches are truncated).

Structure
REQ-030 Shared package riscv_pkg SHALL hold the state enum type imem_state_t, the NOP_WORD constant, and the XLEN=32 constant.
REQ-031 No sub-module is required; the storage array is inferred inline.

Verification
REQ-032 Load 3 words (last on the third) -> load_count=3, cpu_run=1 the cycle after; PC=4 -> Instruction=word 1; PC=12 -> 32'h00000013.
REQ-033 Stream 64 words with load_last never asserted -> RUN after word 63; load_ready=0; a 65th load_valid is ignored and load_count=64.
REQ-034 Reset asserted after 5 words -> load_count=0, IDLE, cpu_run=0; reload 2 words -> PC=8 returns NOP_WORD.
REQ-035 With IMEM_FAULT_EN: in RUN with load_count=22, PC=0x58 -> fault=1, cpu_run=0 next cycle; reload -> fault=0, IDLE.
REQ-036 With IMEM_FAULT_EN: PC=0x02 in RUN -> FAULT; without the macro the same PC returns word 0 and fault stays 0.
REQ-037 In RUN, reload and load_valid both high -> IDLE, load_count=0, and the word is not written as word 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and the instruction-loader state type.
// FAULT is only a member of imem_state_t when IMEM_FAULT_EN is defined.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;
`ifdef IMEM_FAULT_EN
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FAULT} imem_state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, RUN} imem_state_t;
`endif
endpackage

// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if: valid/ready program-load bus from the host to the loader.
interface instr_mem_loader_if;
  logic load_valid;
  logic [riscv_pkg::XLEN-1:0] load_data;
  logic load_last;
  logic load_ready;
  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a program over a valid/ready bus, then serves zero-latency fetches.
// Optional IMEM_FAULT_EN adds a sticky FAULT state for misaligned or out-of-range fetches.
module instr_mem_loader #(
  parameter int DEPTH = 64,
  parameter logic [31:0] NOP_WORD = riscv_pkg::NOP_WORD
) (
  input  logic clk,
  input  logic reset,
  instr_mem_loader_if.slave load,
  input  logic reload,
  input  logic [riscv_pkg::XLEN-1:0] PC,
  output logic [riscv_pkg::XLEN-1:0] Instruction,
  output logic cpu_run,
  output logic [6:0] load_count,
  output logic fault
);
  import riscv_pkg::*;
  localparam int IW = $clog2(DEPTH);
  localparam logic [6:0] LAST = 7'(DEPTH - 1);
  imem_state_t state_q, state_d;
  logic [6:0] cnt_d;
  logic accept, in_range;
  logic [IW-1:0] idx;
  logic [31:0] mem [DEPTH];
  assign load.load_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept = load.load_ready && load.load_valid && !reload;
  assign cpu_run = state_q == RUN;
  assign idx = PC[IW+1:2];
  assign in_range = PC[XLEN-1:2] < {{(XLEN-9){1'b0}}, load_count};
  assign Instruction = (cpu_run && in_range) ? mem[idx] : NOP_WORD;
`ifdef IMEM_FAULT_EN
  assign fault = state_q == FAULT;
`else
  logic unused_pc;
  assign fault = 1'b0;
  assign unused_pc = ^PC[1:0];
`endif
  // reload outranks a simultaneous load handshake; accept already excludes it
  always_comb begin
    state_d = state_q;
    cnt_d = load_count;
    if (reload) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = load_count + 7'd1;
      state_d = (load.load_last || load_count == LAST) ? RUN : LOAD;
    end
`ifdef IMEM_FAULT_EN
    else if (cpu_run && (PC[1:0] != 2'b00 || !in_range))
      state_d = FAULT;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      load_count <= '0;
    end else begin
      state_q <= state_d;
      load_count <= cnt_d;
    end
  end
  // storage is never cleared; stale words are hidden by the load_count mask
  always_ff @(posedge clk)
    if (accept) mem[load_count[IW-1:0]] <= load.load_data;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized checks against a queue-based program model.
module tb_instr_mem_loader;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, reset = 1'b1, reload = 1'b0;
  logic [31:0] PC = '0, Instruction;
  logic cpu_run, fault;
  logic [6:0] load_count;
  int errors = 0, checks = 0;
  instr_mem_loader_if lbus();
  instr_mem_loader dut (
    .clk(clk), .reset(reset), .load(lbus), .reload(reload), .PC(PC),
    .Instruction(Instruction), .cpu_run(cpu_run), .load_count(load_count), .fault(fault)
  );
  always #5 clk = ~clk;
  // model: the loaded program is a queue; phase 0 idle, 1 loading, 2 running, 3 faulted
  int phase = 0;
  logic [31:0] prog[$];
  always @(posedge clk or posedge reset) begin
    if (reset || reload) begin
      phase = 0;
      prog.delete();
    end else if (phase <= 1 && lbus.load_valid) begin
      prog.push_back(lbus.load_data);
      phase = (lbus.load_last || prog.size() == 64) ? 2 : 1;
    end
`ifdef IMEM_FAULT_EN
    else if (phase == 2 && (PC[1:0] != 2'b00 || int'(PC >> 2) >= prog.size()))
      phase = 3;
`endif
  end
  function automatic logic [31:0] exp_instr();
    int i;
    i = int'(PC >> 2);
    if (phase == 2 && i < prog.size()) return prog[i];
    return NOP;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("load_ready", 32'(lbus.load_ready), 32'(phase <= 1));
    check("cpu_run", 32'(cpu_run), 32'(phase == 2));
    check("load_count", 32'(load_count), 32'(prog.size()));
    check("fault", 32'(fault), 32'(phase == 3));
    check("Instruction", Instruction, exp_instr());
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic send(logic [31:0] d, logic l);
    lbus.load_valid = 1'b1;
    lbus.load_data = d;
    lbus.load_last = l;
    tick();
    lbus.load_valid = 1'b0;
    lbus.load_last = 1'b0;
  endtask
  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask
  initial begin
    lbus.load_valid = 1'b0;
    lbus.load_data = '0;
    lbus.load_last = 1'b0;
    repeat (2) tick();
    #1;
    check("rst_count", 32'(load_count), 32'd0);
    check("rst_ready", 32'(lbus.load_ready), 32'd1);
    check("rst_run", 32'(cpu_run), 32'd0);
    check("rst_instr", Instruction, 32'h0000_0013);
    reset = 1'b0;
    // three-word program
    send(32'hA000_0000, 1'b0);
    send(32'hA000_0001, 1'b0);
    send(32'hA000_0002, 1'b1);
    check("a_count", 32'(load_count), 32'd3);
    check("a_run", 32'(cpu_run), 32'd1);
    PC = 32'd4;
    #1 check("a_pc4", Instruction, 32'hA000_0001);
    PC = 32'd12;
    #1 check("a_pc12", Instruction, 32'h0000_0013);
    PC = '0;
    // fill all 64 entries without load_last
    do_reload();
    for (int i = 0; i < 64; i++) send(32'hB000_0000 + 32'(i), 1'b0);
    check("b_ready", 32'(lbus.load_ready), 32'd0);
    check("b_run", 32'(cpu_run), 32'd1);
    check("b_count", 32'(load_count), 32'd64);
    PC = 32'd252;
    #1 check("b_last_word", Instruction, 32'hB000_003F);
    PC = 32'd256;
    #1 check("b_past_end", Instruction, 32'h0000_0013);
    PC = '0;
    send(32'hDEAD_BEEF, 1'b0);
    check("b_65th", 32'(load_count), 32'd64);
    // reset in the middle of a load
    do_reload();
    for (int i = 0; i < 5; i++) send(32'hC000_0000 + 32'(i), 1'b0);
    reset = 1'b1;
    #1;
    check("c_count", 32'(load_count), 32'd0);
    check("c_run", 32'(cpu_run), 32'd0);
    check("c_ready", 32'(lbus.load_ready), 32'd1);
    check("c_instr", Instruction, 32'h0000_0013);
    tick();
    reset = 1'b0;
    send(32'hC100_0000, 1'b0);
    send(32'hC100_0001, 1'b1);
    PC = 32'd8;
    #1 check("c_pc8", Instruction, 32'h0000_0013);
    PC = 32'd4;
    #1 check("c_pc4", Instruction, 32'hC100_0001);
    PC = '0;
    // reload and load_valid together while running
    reload = 1'b1;
    lbus.load_valid = 1'b1;
    lbus.load_data = 32'hDEAD_0000;
    lbus.load_last = 1'b1;
    tick();
    reload = 1'b0;
    lbus.load_valid = 1'b0;
    lbus.load_last = 1'b0;
    check("d_count", 32'(load_count), 32'd0);
    check("d_ready", 32'(lbus.load_ready), 32'd1);
    check("d_run", 32'(cpu_run), 32'd0);
    send(32'h600D_0000, 1'b1);
    check("d_word0", Instruction, 32'h600D_0000);
    // misaligned fetch
    PC = 32'd2;
    #1 check("e_pc2", Instruction, 32'h600D_0000);
    tick();
`ifdef IMEM_FAULT_EN
    check("e_fault", 32'(fault), 32'd1);
    check("e_run", 32'(cpu_run), 32'd0);
`else
    check("e_fault", 32'(fault), 32'd0);
    check("e_run", 32'(cpu_run), 32'd1);
`endif
    PC = '0;
    // fetch just past a 22-word program
    do_reload();
    for (int i = 0; i < 22; i++) send(32'hF000_0000 + 32'(i), i == 21);
    PC = 32'h58;
    #1 check("f_instr", Instruction, 32'h0000_0013);
    tick();
`ifdef IMEM_FAULT_EN
    check("f_fault", 32'(fault), 32'd1);
    check("f_run", 32'(cpu_run), 32'd0);
`else
    check("f_fault", 32'(fault), 32'd0);
    check("f_run", 32'(cpu_run), 32'd1);
`endif
    PC = '0;
    do_reload();
    check("f_clear", 32'(fault), 32'd0);
    check("f_idle", 32'(lbus.load_ready), 32'd1);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r, w;
      reset = ($urandom_range(0, 199) == 0);
      reload = ($urandom_range(0, 39) == 0);
      lbus.load_valid = ($urandom_range(0, 9) < 7);
      lbus.load_data = $urandom;
      lbus.load_last = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 15);
      w = $urandom_range(0, 70);
      PC = (r == 0) ? 32'hFFFF_FFFC :
           (r == 1) ? 32'(w * 4 + $urandom_range(1, 3)) : 32'(w * 4);
      tick();
    end
    reset = 1'b0;
    reload = 1'b0;
    lbus.load_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
